// File: rtl/bus_rr_arbiter_if.sv
// rtl/bus_rr_arbiter_if.sv - master/slave bus bundle shared through the round-robin arbiter
interface bus_rr_arbiter_if #(
    parameter int N_MASTERS = 4,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32
);
    logic [N_MASTERS-1:0]        m_req;
    logic [N_MASTERS*ADDR_W-1:0] m_addr;
    logic [N_MASTERS*DATA_W-1:0] m_data;
    logic [N_MASTERS-1:0]        m_gnt;
    logic                        s_req;
    logic [ADDR_W-1:0]           s_addr;
    logic [DATA_W-1:0]           s_data;
    logic                        s_ready;

    // Agent side: masters drive requests, the slave drives ready
    modport master (
        output m_req, m_addr, m_data, s_ready,
        input  m_gnt, s_req, s_addr, s_data
    );

    // Arbiter side
    modport slave (
        input  m_req, m_addr, m_data, s_ready,
        output m_gnt, s_req, s_addr, s_data
    );
endinterface

// File: rtl/bus_rr_arbiter.sv
// rtl/bus_rr_arbiter.sv - round-robin arbiter sharing one bus slave between N masters
module bus_rr_arbiter #(
    parameter int N_MASTERS = 4,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int MAX_HOLD  = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    bus_rr_arbiter_if.slave              bus,
    output logic                         o_busy,
    output logic [$clog2(N_MASTERS)-1:0] o_owner_id
);
    localparam int ID_W   = $clog2(N_MASTERS);
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [N_MASTERS-1:0]  r_gnt, w_gnt_nxt;
    logic [ID_W-1:0]       r_owner, w_owner_nxt;
    logic [ID_W-1:0]       r_last, w_last_nxt;
    logic [HOLD_W-1:0]     r_hold, w_hold_nxt;

    logic [N_MASTERS-1:0]  w_owner_mask;
    logic [N_MASTERS-1:0]  w_cand;
    logic [ID_W-1:0]       w_winner;
    logic                  w_found;
    logic                  w_beat;
    logic                  w_others;
    logic                  w_hold_max;
    logic                  w_release;
    int                    w_idx;

    // Owner-relative status: beat completion, competing requests, release decision
    always_comb begin
        w_owner_mask = N_MASTERS'(1) << r_owner;
        w_others     = |(bus.m_req & ~w_owner_mask);
        w_beat       = (r_state == ST_GRANT) & bus.m_req[r_owner] & r_gnt[r_owner] & bus.s_ready;
        w_hold_max   = (r_hold == HOLD_W'(MAX_HOLD - 1));
        w_release    = (r_state == ST_GRANT) &
                       (~bus.m_req[r_owner] | (w_beat & w_hold_max & w_others));
        // The releasing owner may not win its own re-arbitration
        w_cand       = (r_state == ST_GRANT) ? (bus.m_req & ~w_owner_mask) : bus.m_req;
    end

    // Rotating priority search starting just after the last winner
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        for (int k = 1; k <= N_MASTERS; k++) begin
            w_idx = (int'(r_last) + k) % N_MASTERS;
            if (!w_found && w_cand[w_idx[ID_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[ID_W-1:0];
            end
        end
    end

    // Next-state and next-grant logic
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_hold_nxt  = r_hold;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_GRANT;
                    w_gnt_nxt   = N_MASTERS'(1) << w_winner;
                    w_owner_nxt = w_winner;
                    w_last_nxt  = w_winner;
                    w_hold_nxt  = '0;
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    if (w_found) begin
                        // Hand over directly, no idle bubble
                        w_gnt_nxt   = N_MASTERS'(1) << w_winner;
                        w_owner_nxt = w_winner;
                        w_last_nxt  = w_winner;
                        w_hold_nxt  = '0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_gnt_nxt   = '0;
                        w_owner_nxt = '0;
                    end
                end else if (w_beat && !w_hold_max) begin
                    w_hold_nxt = r_hold + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
                w_owner_nxt = '0;
            end
        endcase
    end

    // State register with synchronous reset; master 0 first after reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_owner <= '0;
            r_last  <= ID_W'(N_MASTERS - 1);
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    // Slave-side mux: AND-OR over the registered one-hot grant, zero when idle
    always_comb begin
        bus.s_addr = '0;
        bus.s_data = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (r_gnt[i]) begin
                bus.s_addr = bus.s_addr | bus.m_addr[i*ADDR_W +: ADDR_W];
                bus.s_data = bus.s_data | bus.m_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign bus.m_gnt  = r_gnt;
    assign bus.s_req  = |(bus.m_req & r_gnt);
    assign o_busy     = (r_state == ST_GRANT);
    assign o_owner_id = r_owner;

endmodule
